// File: rtl/eq_load_ctrl.sv
// Board sequencer for an N-bit equality comparator: debounces two buttons,
// loads operands A then B from the switch bus, lights the LED on a match and counts matches.
module eq_load_ctrl #(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] no,
  input  logic             push1,
  input  logic             push2,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             valid,
  output logic             ledpin,
  output logic [1:0]       state_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_B = 2'd1,
    S_DONE   = 2'd2,
    S_BAD    = 2'd3
  } state_t;

  // Bit 0 carries push1, bit 1 carries push2 through the whole input path.
  logic [1:0]    w_raw;
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_deb;
  logic [1:0]    r_deb_d;
  logic [CW-1:0] r_dcnt [2];
  logic [1:0]    w_press;

  assign w_raw   = {push2, push1};
  assign w_press = r_deb & ~r_deb_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == CNT_LAST) begin
          r_deb[i]  <= ~r_deb[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  state_t           r_state;
  state_t           w_next;
  logic             w_load_a;
  logic             w_load_b;
  logic             w_hit;
  logic             w_eq;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_match;

  // A press on push1 always wins; a simultaneous push2 press is dropped.
  always_comb begin
    w_next   = r_state;
    w_load_a = 1'b0;
    w_load_b = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press[0]) begin
          w_load_a = 1'b1;
          w_next   = S_WAIT_B;
        end
      end
      S_WAIT_B, S_DONE: begin
        if (w_press[0]) begin
          w_load_a = 1'b1;
          w_next   = S_WAIT_B;
        end else if (w_press[1]) begin
          w_load_b = 1'b1;
          w_next   = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_hit = w_load_b && (no == r_a);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_match <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_a) r_a <= no;
      if (w_load_b) r_b <= no;
      if (w_hit && (r_match != {CNT_W{1'b1}})) r_match <= r_match + 1'b1;
    end
  end

  assign w_eq      = &(r_a ~^ r_b);
  assign a_q       = r_a;
  assign b_q       = r_b;
  assign valid     = (r_state == S_DONE);
  assign ledpin    = valid & w_eq;
  assign state_q   = r_state;
  assign match_cnt = r_match;

endmodule
